// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared types and defaults for the shift-window sequencer
// Purpose : FSM state encoding, default parameters and a counter-width helper.
// Ports   : none (package).
package shift_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      WIN,
      FINAL,
      DONE
   } state_t;

   localparam int DEPTH_DEF  = 4;
   localparam int DATA_W_DEF = 8;
   localparam int LEN_W_DEF  = 8;

   // Width of a counter spanning 0..depth-1; never narrower than one bit.
   function automatic int fill_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/win_fill_counter.sv
// rtl/win_fill_counter.sv - window fill counter with clear and last-entry flag
// Purpose : counts bytes pushed into the current window.
// Ports   : clk, rst (sync, active-high), inc (count one byte), clear (restart window),
//           fill (current count), last (fill == DEPTH-1).
module win_fill_counter
   import shift_ctrl_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int FILL_W = fill_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clear,
   output logic [FILL_W-1:0] fill,
   output logic              last
);

   assign last = (fill == FILL_W'(DEPTH - 1));

   // Holds at DEPTH-1 instead of wrapping; only an explicit clear restarts the window.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         fill <= '0;
      end else if (inc && !last) begin
         fill <= fill + 1'b1;
      end
   end

endmodule

// File: rtl/shift_window_ctrl.sv
// rtl/shift_window_ctrl.sv - sequencer for the 4x8-bit shift-register window buffer
// Purpose : accepts a byte stream, drives the buffer's inp/shift/final_output controls,
//           presents each full window, zero-pads a partial last window and then runs
//           one final-readout phase.
// Ports   : clk, rst (sync, active-high); start/len job request; in_data/in_valid/in_ready
//           byte stream; sr_inp/sr_shift/sr_final_output buffer controls;
//           win_valid/win_ready window handshake; busy, done (1-cycle) status.
module shift_window_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] sr_inp,
   output logic              sr_shift,
   output logic              sr_final_output,
   output logic              win_valid,
   input  logic              win_ready,
   output logic              busy,
   output logic              done
);

   localparam int FILL_W = fill_width(DEPTH);

   state_t             state;
   logic [LEN_W-1:0]   remaining;
   logic [FILL_W-1:0]  fill;
   logic               fill_last;
   logic               accept;
   logic               fill_inc;
   logic               fill_clear;

   assign accept     = (state == LOAD) && in_valid;
   assign fill_inc   = accept || (state == PAD);
   assign fill_clear = ((state == IDLE) && start) || ((state == WIN) && win_ready);

   win_fill_counter #(
      .DEPTH  (DEPTH),
      .FILL_W (FILL_W)
   ) u_fill (
      .clk   (clk),
      .rst   (rst),
      .inc   (fill_inc),
      .clear (fill_clear),
      .fill  (fill),
      .last  (fill_last)
   );

   // Status and window outputs are decoded from the state register only.
   assign in_ready        = (state == LOAD);
   assign win_valid       = (state == WIN) || (state == FINAL);
   assign sr_final_output = (state == FINAL);
   assign busy            = (state != IDLE);
   assign done            = (state == DONE);

   // Data path follows the source directly in LOAD so a byte shifts on its accept edge;
   // PAD pushes zeros into the newest lanes.
   assign sr_shift = (state == LOAD) ? in_valid : (state == PAD);
   assign sr_inp   = (state == LOAD) ? in_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= len;
                  state     <= (len != '0) ? LOAD : DONE;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (remaining != '0) begin
                     remaining <= remaining - 1'b1;
                  end
                  if (fill_last) begin
                     state <= WIN;
                  end else if (remaining == LEN_W'(1)) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               if (fill_last) begin
                  state <= WIN;
               end
            end
            WIN: begin
               if (win_ready) begin
                  state <= (remaining != '0) ? LOAD : FINAL;
               end
            end
            FINAL: begin
               if (win_ready) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
